// File: rtl/face_reader.sv
// Skin-tone face locator: captures one RGB frame into a 1-bit skin mask,
// divides the accumulated coordinate sums for the centroid, then streams the mask out.
module face_reader #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] r_in,
    input  logic [DEPTH-1:0] g_in,
    input  logic [DEPTH-1:0] b_in,
    input  logic             enable,
    input  logic             enable_process,
    output logic [DEPTH-1:0] image_output,
    output logic [7:0]       centroid_x,
    output logic [7:0]       centroid_y,
    output logic             centroid_ready,
    output logic             finish
);
    localparam int LOG_W     = $clog2(IMG_WIDTH);
    localparam int LOG_N     = LOG_W + $clog2(IMG_HEIGHT);
    localparam int N         = IMG_WIDTH * IMG_HEIGHT;
    localparam int SUM_W     = 24;
    localparam int CNT_W     = 17;
    localparam int DIV_STEPS = 24;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STREAM, S_DONE} state_t;
    state_t state, state_nxt;

    logic             vld_p0, vld_p1;
    logic             cap, last_cap, skin_p0, rd_en, mem_q;
    logic [LOG_N-1:0] wr_k;
    logic [LOG_N:0]   rd_k;
    logic [SUM_W-1:0] sum_x, sum_y, x_ext, y_ext;
    logic [CNT_W-1:0] count;
    logic             div_go;
    logic [4:0]       div_cnt;
    logic [SUM_W-1:0] qx, qy;
    logic [CNT_W:0]   remx, remy;
    logic [CNT_W+SUM_W:0] stx, sty;
    logic             mask [N];

    function automatic logic is_skin(input logic [DEPTH-1:0] r, input logic [DEPTH-1:0] g,
                                     input logic [DEPTH-1:0] b);
        // r > g guards the subtraction, so the difference never wraps
        return (r > DEPTH'(95)) && (g > DEPTH'(40)) && (b > DEPTH'(20)) &&
               (r > g) && (r > b) && ((r - g) > DEPTH'(15));
    endfunction

    function automatic logic [CNT_W+SUM_W:0] div_step(input logic [CNT_W:0] rem,
                                                      input logic [SUM_W-1:0] q,
                                                      input logic [CNT_W-1:0] d);
        logic [CNT_W:0]        trial;
        logic [CNT_W+SUM_W:0]  res;
        trial = {rem[CNT_W-1:0], q[SUM_W-1]};
        if (trial >= {1'b0, d})
            res = {trial - {1'b0, d}, q[SUM_W-2:0], 1'b1};
        else
            res = {trial, q[SUM_W-2:0], 1'b0};
        return res;
    endfunction

    assign cap      = vld_p0 && (state == S_LOAD);
    assign last_cap = cap && (&wr_k);
    assign skin_p0  = is_skin(r_in, g_in, b_in);
    assign rd_en    = (state == S_STREAM) && !rd_k[LOG_N];
    assign x_ext    = SUM_W'(wr_k[LOG_W-1:0]);
    assign y_ext    = SUM_W'(wr_k[LOG_N-1:LOG_W]);
    assign stx      = div_step(remx, qx, count);
    assign sty      = div_step(remy, qy, count);
    assign image_output = {DEPTH{vld_p1 && mem_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable)         state_nxt = S_LOAD;
            S_LOAD:   if (last_cap)       state_nxt = S_WAIT;
            S_WAIT:   if (enable_process) state_nxt = S_STREAM;
            S_STREAM: if (rd_k[LOG_N])    state_nxt = S_DONE;
            default:                      state_nxt = state;
        endcase
    end

    // p0: sample arrives one cycle after its enable; classify and accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0         <= 1'b0;
            vld_p1         <= 1'b0;
            wr_k           <= '0;
            rd_k           <= '0;
            sum_x          <= '0;
            sum_y          <= '0;
            count          <= '0;
            finish         <= 1'b0;
            div_go         <= 1'b0;
            div_cnt        <= '0;
            centroid_x     <= '0;
            centroid_y     <= '0;
            centroid_ready <= 1'b0;
        end else begin
            vld_p0 <= enable;
            if (cap) begin
                wr_k <= wr_k + 1'b1;
                if (skin_p0) begin
                    sum_x <= sum_x + x_ext;
                    sum_y <= sum_y + y_ext;
                    count <= count + CNT_W'(1);
                end
            end
            if (rd_en) rd_k <= rd_k + 1'b1;
            vld_p1 <= rd_en;
            finish <= (state_nxt == S_STREAM);
            div_go <= last_cap;
            if (div_go) begin
                div_cnt <= 5'(DIV_STEPS);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
                if (div_cnt == 5'd1) begin
                    centroid_x     <= (count == '0) ? 8'd0 : stx[7:0];
                    centroid_y     <= (count == '0) ? 8'd0 : sty[7:0];
                    centroid_ready <= 1'b1;
                end
            end
        end
    end

    // Divider datapath: sums are final one cycle after the last capture
    always_ff @(posedge clk) begin
        if (div_go) begin
            qx   <= sum_x;
            qy   <= sum_y;
            remx <= '0;
            remy <= '0;
        end else if (div_cnt != '0) begin
            {remx, qx} <= stx;
            {remy, qy} <= sty;
        end
    end

    // p1: mask RAM, written during load, read during stream
    always_ff @(posedge clk) begin
        if (cap)   mask[wr_k] <= skin_p0;
        if (rd_en) mem_q      <= mask[rd_k[LOG_N-1:0]];
    end
endmodule

// File: tb/tb_face_reader.sv
// Bench for face_reader on a reduced 32x32 frame; a reference model derives
// mask and centroid straight from the skin rule with plain integer arithmetic.
module tb_face_reader;
    localparam int W = 32;
    localparam int H = 32;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic       enable = 1'b0, enable_process = 1'b0;
    logic [7:0] image_output, centroid_x, centroid_y;
    logic       centroid_ready, finish;

    int n_checks = 0;
    int n_fail   = 0;
    int fr_r [N];
    int fr_g [N];
    int fr_b [N];
    bit exp_mask [N];
    int exp_cx, exp_cy;

    face_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .enable(enable), .enable_process(enable_process),
        .image_output(image_output), .centroid_x(centroid_x), .centroid_y(centroid_y),
        .centroid_ready(centroid_ready), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit skin_ref(input int r, input int g, input int b);
        return r > 95 && g > 40 && b > 20 && r > g && r > b && (r - g) > 15;
    endfunction

    task automatic build_model();
        longint sx = 0, sy = 0, cnt = 0;
        for (int k = 0; k < N; k++) begin
            exp_mask[k] = skin_ref(fr_r[k], fr_g[k], fr_b[k]);
            if (exp_mask[k]) begin
                sx += k % W;
                sy += k / W;
                cnt++;
            end
        end
        exp_cx = (cnt == 0) ? 0 : int'((sx / cnt) % 256);
        exp_cy = (cnt == 0) ? 0 : int'((sy / cnt) % 256);
    endtask

    task automatic fill_const(input int r, input int g, input int b);
        for (int k = 0; k < N; k++) begin
            fr_r[k] = r; fr_g[k] = g; fr_b[k] = b;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                fr_r[k] = $urandom_range(90, 255);
                fr_g[k] = $urandom_range(30, 200);
                fr_b[k] = $urandom_range(15, 200);
            end else begin
                fr_r[k] = $urandom_range(0, 255);
                fr_g[k] = $urandom_range(0, 255);
                fr_b[k] = $urandom_range(0, 255);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        enable_process = 1'b0;
        #1;
        check("rst_image_output", image_output, 0);
        check("rst_centroid_x", centroid_x, 0);
        check("rst_centroid_y", centroid_y, 0);
        check("rst_centroid_ready", centroid_ready, 0);
        check("rst_finish", finish, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pixel k is presented in the cycle after the enable that requested it.
    task automatic load_frame(input bit gaps, input bit hold_en, input int abort_at);
        int issued = 0;
        int data_idx = 0;
        bit pend = 0;
        bit en;
        while (data_idx < N) begin
            @(negedge clk);
            if (pend) begin
                r_in = 8'(fr_r[data_idx]);
                g_in = 8'(fr_g[data_idx]);
                b_in = 8'(fr_b[data_idx]);
                data_idx++;
            end else if (hold_en && issued == N) begin
                r_in = 8'd200; g_in = 8'd100; b_in = 8'd50;
            end
            if (abort_at >= 0 && data_idx >= abort_at) return;
            if (issued < N) en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            else            en = hold_en;
            enable = en;
            pend = en && (issued < N);
            if (pend) issued++;
        end
    endtask

    task automatic readout(input string tag, input bit pre);
        int bad = 0;
        @(negedge clk);
        check({tag, "_wait_finish"}, finish, 0);
        if (!pre) begin
            check({tag, "_ready_early"}, centroid_ready, 0);
            repeat (5) @(negedge clk);
            check({tag, "_wait_finish_idle"}, finish, 0);
        end
        enable_process = 1'b1;
        @(negedge clk);
        if (finish !== 1'b1) bad++;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (finish !== 1'b1 || image_output !== (exp_mask[k] ? 8'd255 : 8'd0)) bad++;
        end
        check({tag, "_stream_bad_pixels"}, bad, 0);
        @(negedge clk);
        check({tag, "_end_finish"}, finish, 0);
        check({tag, "_end_image"}, image_output, 0);
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit hold_en, input bit pre);
        int bad = 0;
        do_reset();
        build_model();
        if (pre) enable_process = 1'b1;
        load_frame(gaps, hold_en, -1);
        readout(tag, pre);
        check({tag, "_ready"}, centroid_ready, 1);
        check({tag, "_cx"}, centroid_x, exp_cx);
        check({tag, "_cy"}, centroid_y, exp_cy);
        enable = 1'b1;
        enable_process = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (finish !== 1'b0 || image_output !== 8'd0) bad++;
        end
        check({tag, "_done_quiet"}, bad, 0);
        check({tag, "_done_ready"}, centroid_ready, 1);
    endtask

    initial begin
        fill_const(200, 100, 50);
        run_frame("all_skin", 1'b0, 1'b0, 1'b0);
        check("all_skin_cx_const", centroid_x, 15);
        check("all_skin_cy_const", centroid_y, 15);

        fill_const(50, 50, 50);
        run_frame("no_skin", 1'b0, 1'b0, 1'b0);
        check("no_skin_cx_zero", centroid_x, 0);

        fill_const(50, 50, 50);
        fr_r[20*W+10] = 200; fr_g[20*W+10] = 100; fr_b[20*W+10] = 50;
        run_frame("single", 1'b1, 1'b0, 1'b0);
        check("single_cx_const", centroid_x, 10);
        check("single_cy_const", centroid_y, 20);

        fill_const(50, 50, 50);
        for (int y = 10; y <= 11; y++)
            for (int x = 20; x <= 21; x++) begin
                fr_r[y*W+x] = 200; fr_g[y*W+x] = 100; fr_b[y*W+x] = 50;
            end
        run_frame("block", 1'b0, 1'b0, 1'b0);
        check("block_cx_const", centroid_x, 20);
        check("block_cy_const", centroid_y, 10);

        for (int k = 0; k < N; k++) begin
            fr_r[k] = 96; fr_b[k] = 21;
            fr_g[k] = (k % 2 == 0) ? 41 : 81;
        end
        run_frame("boundary", 1'b1, 1'b0, 1'b0);

        fill_random();
        run_frame("rand_hold", 1'b1, 1'b1, 1'b1);

        fill_random();
        do_reset();
        load_frame(1'b1, 1'b0, 400);
        run_frame("after_abort", 1'b1, 1'b0, 1'b0);

        fill_random();
        run_frame("rand_plain", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
